// File: rtl/sid_out_pkg.sv
// Shared constants and types for the SID output stage.
// Optional feature macro: SID_OUT_DITHER_EN (LFSR dither ahead of the modulators).
package sid_out_pkg;

   localparam int unsigned DEF_SAMPLE_W  = 15;
   localparam int unsigned DEF_PWM_W     = 8;
   localparam int unsigned SAMPLE_MID    = 16384;
   localparam int unsigned MUL_CYCLES    = 5;
   localparam int unsigned MULT_W        = 5;
   localparam int unsigned VOL_SHIFT     = 4;
   localparam int unsigned LFSR_W        = 16;
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5
   localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_LOAD
   } state_e;

endpackage

// File: rtl/sid_output_stage_if.sv
// Sample handshake between the filter/mixer and the output stage.
interface sid_output_stage_if
   import sid_out_pkg::*;
#(
   parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
);
   logic [SAMPLE_W-1:0] sample_in;
   logic                sample_valid;
   logic                sample_taken;
   logic                busy;

   modport master (output sample_in, output sample_valid, input sample_taken, input busy);
   modport slave  (input sample_in, input sample_valid, output sample_taken, output busy);
endinterface

// File: rtl/sid_dsm.sv
// First-order delta-sigma modulator: accumulator register, carry is the bitstream.
module sid_dsm
#(
   parameter int unsigned W = 15
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] u,
   output logic         carry_c
);
   logic [W-1:0] acc_q;
   logic [W:0]   sum_c;

   assign sum_c   = {1'b0, acc_q} + {1'b0, u};
   assign carry_c = sum_c[W];

   // Accumulate every cycle; the overflow is the output bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) acc_q <= '0;
      else      acc_q <= sum_c[W-1:0];
   end
endmodule

// File: rtl/sid_output_stage.sv
// SID output stage: volume scaling (serial multiply), then delta-sigma or PWM to a 1-bit pin.
// Optional feature macro: SID_OUT_DITHER_EN adds a 16-bit LFSR dither before the modulators.
module sid_output_stage
   import sid_out_pkg::*;
#(
   parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
   parameter int unsigned PWM_W    = DEF_PWM_W
)(
   input  logic                clk,
   input  logic                rst,
   sid_output_stage_if.slave   mix,
   input  logic [3:0]          vol,
   input  logic                pwm_mode,
   input  logic                overrun_clr,
   output logic                audio_out,
   output logic                overrun
);
   localparam int unsigned PROD_W = SAMPLE_W + MULT_W;

   state_e                     state_q, state_d;
   logic                       valid_q, edge_c;
   logic signed [SAMPLE_W-1:0] s_q, s_d, target_q, target_d;
   logic [MULT_W-1:0]          m_q, m_d;
   logic signed [PROD_W-1:0]   prod_q, prod_d, addend_c, prod_sh_c;
   logic [2:0]                 bit_q, bit_d;
   logic                       taken_q, taken_d, busy_q, busy_d, ovr_d;
   logic [SAMPLE_W-1:0]        u_c, u_mod_c;
   logic                       dsm_bit_c;

   assign edge_c    = mix.sample_valid & ~valid_q;
   assign addend_c  = {{MULT_W{s_q[SAMPLE_W-1]}}, s_q} << bit_q;
   assign prod_sh_c = prod_q >>> VOL_SHIFT;

   // Capture / serial multiply / load sequencing
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      m_d      = m_q;
      prod_d   = prod_q;
      bit_d    = bit_q;
      target_d = target_q;
      taken_d  = 1'b0;
      busy_d   = busy_q;
      ovr_d    = overrun_clr ? 1'b0 : overrun;
      if (edge_c && (state_q != ST_IDLE)) ovr_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (edge_c) begin
               s_d     = mix.sample_in - SAMPLE_W'(SAMPLE_MID);
               m_d     = {1'b0, vol} + MULT_W'(vol == 4'hF);
               prod_d  = '0;
               bit_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            if (m_q[bit_q]) prod_d = prod_q + addend_c;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'(MUL_CYCLES - 1)) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            target_d = prod_sh_c[SAMPLE_W-1:0];
            taken_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         valid_q  <= 1'b0;
         s_q      <= '0;
         m_q      <= '0;
         prod_q   <= '0;
         bit_q    <= '0;
         target_q <= '0;
         taken_q  <= 1'b0;
         busy_q   <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state_q  <= state_d;
         valid_q  <= mix.sample_valid;
         s_q      <= s_d;
         m_q      <= m_d;
         prod_q   <= prod_d;
         bit_q    <= bit_d;
         target_q <= target_d;
         taken_q  <= taken_d;
         busy_q   <= busy_d;
         overrun  <= ovr_d;
      end
   end

   assign mix.sample_taken = taken_q;
   assign mix.busy         = busy_q;

   // Back to offset-binary for the modulators
   assign u_c = $unsigned(target_q) + SAMPLE_W'(SAMPLE_MID);

`ifdef SID_OUT_DITHER_EN
   localparam int unsigned DW = SAMPLE_W + 2;
   logic [LFSR_W-1:0]   lfsr_q;
   logic                lfsr_fb_c;
   logic signed [DW-1:0] dith_sum_c;

   assign lfsr_fb_c = ^(lfsr_q & LFSR_TAP_MASK);

   // Free-running dither source
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr_q <= LFSR_SEED;
      else      lfsr_q <= {lfsr_fb_c, lfsr_q[LFSR_W-1:1]};
   end

   // Add -8..+7 dither and saturate to the unsigned sample range
   always_comb begin
      dith_sum_c = $signed({2'b00, u_c}) + $signed({{(DW-4){1'b0}}, lfsr_q[3:0]})
                   - $signed(DW'(8));
      u_mod_c    = dith_sum_c[SAMPLE_W-1:0];
      if (dith_sum_c < 0)
         u_mod_c = '0;
      else if (dith_sum_c > $signed(DW'((2 ** SAMPLE_W) - 1)))
         u_mod_c = {SAMPLE_W{1'b1}};
   end
`else
   assign u_mod_c = u_c;
`endif

   sid_dsm #(.W(SAMPLE_W)) u_dsm (
      .clk     (clk),
      .rst     (rst),
      .u       (u_mod_c),
      .carry_c (dsm_bit_c)
   );

   logic [PWM_W-1:0] cnt_q, duty_q, duty_c;
   logic             mode_q, mode_c, pwm_bit_c;

   // Duty and mode only change at the start of a PWM period
   assign duty_c    = (cnt_q == '0) ? u_mod_c[SAMPLE_W-1 -: PWM_W] : duty_q;
   assign mode_c    = (cnt_q == '0) ? pwm_mode : mode_q;
   assign pwm_bit_c = cnt_q < duty_c;

   // PWM counter, period latches and registered pin
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         duty_q    <= '0;
         mode_q    <= 1'b0;
         audio_out <= 1'b0;
      end else begin
         cnt_q     <= cnt_q + PWM_W'(1);
         duty_q    <= duty_c;
         mode_q    <= mode_c;
         audio_out <= mode_c ? pwm_bit_c : dsm_bit_c;
      end
   end
endmodule

// File: tb/tb_sid_output_stage.sv
// Scoreboard bench for sid_output_stage: expected targets queued at stimulus, checked on sample_taken.
module tb_sid_output_stage;
   import sid_out_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] vol;
   logic       pwm_mode, overrun_clr, audio_out, overrun;

   always #5 clk = ~clk;

   sid_output_stage_if #(.SAMPLE_W(15)) mix ();

   sid_output_stage dut (
      .clk         (clk),
      .rst         (rst),
      .mix         (mix.slave),
      .vol         (vol),
      .pwm_mode    (pwm_mode),
      .overrun_clr (overrun_clr),
      .audio_out   (audio_out),
      .overrun     (overrun)
   );

   typedef struct {
      logic signed [14:0] tgt;
      int                 at;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, want);
      end
   endtask

   // Monitor: every sample_taken must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst && mix.sample_taken) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_taken cyc=%0d target=%0d", cyc, dut.target_q);
         end else begin
            mon_e = exp_q.pop_front();
            if (dut.target_q !== mon_e.tgt || cyc != mon_e.at) begin
               errors++;
               $display("FAIL target got=%0d at cyc %0d exp=%0d at cyc %0d",
                        dut.target_q, cyc, mon_e.tgt, mon_e.at);
            end
         end
      end
   end

   // One-cycle strobe; optionally queue the expected result 7 cycles later
   task automatic send(input logic [14:0] smp, input logic [3:0] v, input int tgt, input bit push);
      @(negedge clk);
      mix.sample_in    = smp;
      vol              = v;
      mix.sample_valid = 1'b1;
      if (push) exp_q.push_back('{tgt: 15'(tgt), at: cyc + 7});
      @(negedge clk);
      mix.sample_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      chk(name, exp_q.size(), 0);
   endtask

   task automatic count_ones(input int n, output int ones, output int same_pairs);
      logic prev;
      ones       = 0;
      same_pairs = 0;
      prev       = audio_out;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ones += int'(audio_out);
         if (i > 0 && audio_out == prev) same_pairs++;
         prev = audio_out;
      end
   endtask

`ifdef SID_OUT_DITHER_EN
   logic [15:0] lfsr_mdl;
   always @(posedge clk or negedge rst) begin
      if (!rst) lfsr_mdl <= 16'hACE1;
      else      lfsr_mdl <= {lfsr_mdl[0] ^ lfsr_mdl[2] ^ lfsr_mdl[3] ^ lfsr_mdl[5], lfsr_mdl[15:1]};
   end
`endif

   initial begin
      int ones, same, waited;
      rst              = 1'b0;
      vol              = 4'd0;
      pwm_mode         = 1'b0;
      overrun_clr      = 1'b0;
      mix.sample_in    = '0;
      mix.sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_audio", audio_out, 0);
      chk("rst_taken", mix.sample_taken, 0);
      chk("rst_busy", mix.busy, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b1;

      // Full scale, +0.25 of range
      send(15'd24576, 4'd15, 8192, 1'b1);
      chk("busy_mul", mix.busy, 1);
      drain("drain_v15");
`ifndef SID_OUT_DITHER_EN
      count_ones(1024, ones, same);
      checks++;
      if (ones < 767 || ones > 769) begin
         errors++;
         $display("FAIL dsm_density got=%0d exp=768+/-1", ones);
      end
`endif
      send(15'd24576, 4'd8, 4096, 1'b1);
      drain("drain_v8");
      send(15'd0, 4'd15, -16384, 1'b1);
      drain("drain_min");
`ifndef SID_OUT_DITHER_EN
      count_ones(64, ones, same);
      chk("dsm_zero_ones", ones, 0);
`endif
      send(15'd32000, 4'd0, 0, 1'b1);
      drain("drain_vol0");
`ifndef SID_OUT_DITHER_EN
      count_ones(16, ones, same);
      chk("dsm_half_ones", ones, 8);
      chk("dsm_half_toggle", same, 0);
`endif
      // Truncation of the arithmetic shift, both signs
      send(15'd16484, 4'd3, 18, 1'b1);
      drain("drain_pos_trunc");
      send(15'd16284, 4'd3, -19, 1'b1);
      drain("drain_neg_trunc");
      send(15'd8192, 4'd5, -2560, 1'b1);
      drain("drain_v5");

      // Level held high captures once and is not an overrun
      @(negedge clk);
      mix.sample_in    = 15'd32767;
      vol              = 4'd15;
      mix.sample_valid = 1'b1;
      exp_q.push_back('{tgt: 15'(16383), at: cyc + 7});
      repeat (20) @(negedge clk);
      mix.sample_valid = 1'b0;
      drain("drain_level");
      chk("level_no_overrun", overrun, 0);

      // Second edge 3 cycles later is dropped
      send(15'd24576, 4'd15, 8192, 1'b1);
      @(negedge clk);
      send(15'd0, 4'd15, 0, 1'b0);
      drain("drain_overrun");
      chk("overrun_set", overrun, 1);
      repeat (10) @(negedge clk);
      chk("overrun_sticky", overrun, 1);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      chk("overrun_clr", overrun, 0);

      // Reset in the middle of the multiply discards the sample
      send(15'd24576, 4'd8, 0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_audio", audio_out, 0);
      chk("mid_rst_taken", mix.sample_taken, 0);
      chk("mid_rst_busy", mix.busy, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_state", int'(dut.state_q), int'(ST_IDLE));
      @(negedge clk);
      rst = 1'b1;
      chk("post_rst_acc", int'(dut.u_dsm.acc_q), 0);
      chk("post_rst_audio", audio_out, 0);
      repeat (12) @(negedge clk);

`ifdef SID_OUT_DITHER_EN
      // Dither: LFSR tracks the reference, u_d stays within +/-8 of midpoint
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         chk("lfsr_seq", int'(dut.lfsr_q), int'(lfsr_mdl));
         chk("u_dither", int'(dut.u_mod_c), 16384 + int'(lfsr_mdl[3:0]) - 8);
      end
`endif

      // PWM at full scale: 255 of 256 high
      send(15'd32767, 4'd15, 16383, 1'b1);
      drain("drain_pwm_full");
      pwm_mode = 1'b1;
      repeat (600) @(negedge clk);
      count_ones(256, ones, same);
      chk("pwm_full_ones", ones, 255);

      // Mode change mid-period only takes effect after the next period start
      send(15'd16384, 4'd0, 0, 1'b1);
      drain("drain_pwm_mid");
      repeat (300) @(negedge clk);
      waited = 0;
      while (int'(dut.cnt_q) != 100 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= 300) begin
         errors++;
         $display("FAIL pwm_phase_timeout waited=%0d exp<300", waited);
      end
      pwm_mode = 1'b0;
`ifndef SID_OUT_DITHER_EN
      count_ones(156, ones, same);
      chk("pwm_hold_ones", ones, 28);
      count_ones(9, ones, same);
      chk("dsm_after_switch_toggle", same, 0);
`else
      count_ones(156, ones, same);
      checks++;
      if (ones < 27 || ones > 28) begin
         errors++;
         $display("FAIL pwm_hold_ones got=%0d exp=27..28", ones);
      end
`endif
      repeat (10) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
